// File: rtl/disp_pkg.sv
// Shared definitions for the display scanner: nibble width, scan state type
// and width helpers used to size ports and slices.
package disp_pkg;

    localparam int NIB_W = 4;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    // Width of one packed source word.
    function automatic int slice_w(input int digits);
        return digits * NIB_W;
    endfunction

    // Index/select width, never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/disp_prescaler.sv
// Digit hold-time prescaler: counts 0..PRESCALE-1 while run is high and flags
// the last cycle of each hold period on tick.
module disp_prescaler #(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic tick
);

    localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [CNT_W-1:0] cnt;

    assign tick = run && (cnt == CNT_W'(PRESCALE - 1));

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset || !run) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/disp_scan.sv
// Multi-source display scanner: snapshots one packed word and serialises its
// nibbles MSB-first. Define DISP_SCAN_BLANK_EN to enable leading-zero blanking.
module disp_scan
    import disp_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int NUM_SRC  = 2,
    parameter int PRESCALE = 1
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [NUM_SRC*slice_w(DIGITS)-1:0]   src_data,
    input  logic [idx_w(NUM_SRC)-1:0]            src_sel,
    input  logic                                 enable,
    output logic [NIB_W-1:0]                     display_out,
    output logic [idx_w(DIGITS)-1:0]             digit_idx,
    output logic [DIGITS-1:0]                    digit_en,
    output logic                                 sync,
    output logic                                 frame_done
);

    localparam int SRC_W = slice_w(DIGITS);
    localparam int IDX_W = idx_w(DIGITS);
    localparam int SEL_W = idx_w(NUM_SRC);

    state_t            state;
    logic [SRC_W-1:0]  snap;
    logic [SRC_W-1:0]  sel_word;
    logic [IDX_W-1:0]  nxt_idx;
    logic [DIGITS-1:0] load_mask;
    logic [DIGITS-1:0] cur_mask;
    logic              tick;
    logic              last_digit;
    logic              advance;
    logic              load;

    function automatic logic [NIB_W-1:0] nib_at(input logic [SRC_W-1:0] w,
                                                input logic [IDX_W-1:0] i);
        nib_at = '0;
        for (int d = 0; d < DIGITS; d++) begin
            if (i == IDX_W'(d)) nib_at = w[d*NIB_W +: NIB_W];
        end
    endfunction

    // Out-of-range selects fall back to source 0.
    // NOTE: combinational blocks assign a default first so no path can infer a latch.
    always_comb begin
        sel_word = src_data[SRC_W-1:0];
        for (int k = 1; k < NUM_SRC; k++) begin
            if (src_sel == SEL_W'(k)) sel_word = src_data[k*SRC_W +: SRC_W];
        end
    end

`ifdef DISP_SCAN_BLANK_EN
    logic [DIGITS-1:0] mask_q;
    logic              nz_seen;

    // A digit is shown if it or any more significant nibble is non-zero; digit 0 always shows.
    always_comb begin
        load_mask    = '0;
        load_mask[0] = 1'b1;
        nz_seen      = 1'b0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            if (sel_word[i*NIB_W +: NIB_W] != '0) nz_seen = 1'b1;
            load_mask[i] = nz_seen;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mask_q <= '0;
        end else if (load) begin
            mask_q <= load_mask;
        end
    end

    assign cur_mask = mask_q;
`else
    assign load_mask = '1;
    assign cur_mask  = '1;
`endif

    disp_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .run   (state == SCAN),
        .tick  (tick)
    );

    assign last_digit = (state == SCAN) && tick && (digit_idx == '0);
    assign advance    = (state == SCAN) && tick && (digit_idx != '0);
    assign load       = enable && ((state == IDLE) || last_digit);
    assign nxt_idx    = digit_idx - IDX_W'(1);

    // Decoded purely from flops, so there is no input-to-output path.
    assign frame_done = last_digit;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            snap        <= '0;
            display_out <= '0;
            digit_idx   <= '0;
            digit_en    <= '0;
            sync        <= 1'b0;
        end else if (load) begin
            state       <= SCAN;
            snap        <= sel_word;
            digit_idx   <= IDX_W'(DIGITS - 1);
            display_out <= load_mask[DIGITS-1] ? sel_word[SRC_W-1 -: NIB_W] : '0;
            digit_en    <= {load_mask[DIGITS-1], {(DIGITS-1){1'b0}}};
            sync        <= 1'b1;
        end else if (last_digit) begin
            state       <= IDLE;
            display_out <= '0;
            digit_idx   <= '0;
            digit_en    <= '0;
            sync        <= 1'b0;
        end else if (advance) begin
            digit_idx   <= nxt_idx;
            display_out <= cur_mask[nxt_idx] ? nib_at(snap, nxt_idx) : '0;
            digit_en    <= (DIGITS'(1) << nxt_idx) & cur_mask;
            sync        <= 1'b0;
        end else begin
            sync        <= 1'b0;
        end
    end

endmodule

// File: tb/tb_disp_scan.sv
// Directed bench for disp_scan: a PRESCALE=1 and a PRESCALE=3 instance share
// stimulus; each task checks one scenario against hand-computed vectors.
module tb_disp_scan;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [31:0] src_data = '0;
    logic [0:0]  src_sel = '0;

    logic [3:0]  a_disp, b_disp;
    logic [1:0]  a_idx, b_idx;
    logic [3:0]  a_en, b_en;
    logic        a_sync, b_sync, a_fd, b_fd;
    logic [11:0] obs_a, obs_b;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    disp_scan #(.DIGITS(4), .NUM_SRC(2), .PRESCALE(1)) dut_a (
        .clk (clk), .reset (reset), .src_data (src_data), .src_sel (src_sel),
        .enable (enable), .display_out (a_disp), .digit_idx (a_idx),
        .digit_en (a_en), .sync (a_sync), .frame_done (a_fd)
    );

    disp_scan #(.DIGITS(4), .NUM_SRC(2), .PRESCALE(3)) dut_b (
        .clk (clk), .reset (reset), .src_data (src_data), .src_sel (src_sel),
        .enable (enable), .display_out (b_disp), .digit_idx (b_idx),
        .digit_en (b_en), .sync (b_sync), .frame_done (b_fd)
    );

    // Packed as {display_out, digit_idx, digit_en, sync, frame_done}.
    assign obs_a = {a_disp, a_idx, a_en, a_sync, a_fd};
    assign obs_b = {b_disp, b_idx, b_en, b_sync, b_fd};

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        enable = 1'b0;
        step();
        reset  = 1'b0;
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        enable = 1'b1;
        step();
        step();
        n_checks++;
        if (obs_a !== 12'h000) begin
            n_errors++;
            $display("FAIL reset_a: got %h expected 000", obs_a);
        end
        n_checks++;
        if (obs_b !== 12'h000) begin
            n_errors++;
            $display("FAIL reset_b: got %h expected 000", obs_b);
        end
        reset  = 1'b0;
        enable = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            n_checks++;
            if (obs_a !== 12'h000 || obs_b !== 12'h000) begin
                n_errors++;
                $display("FAIL idle_hold cycle %0d: got %h/%h expected 000/000", c, obs_a, obs_b);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [11:0] exp_tab [8];
        exp_tab = '{ {4'h1, 2'd3, 4'b1000, 1'b1, 1'b0}, {4'h2, 2'd2, 4'b0100, 1'b0, 1'b0},
                     {4'h3, 2'd1, 4'b0010, 1'b0, 1'b0}, {4'h4, 2'd0, 4'b0001, 1'b0, 1'b1},
                     {4'h1, 2'd3, 4'b1000, 1'b1, 1'b0}, {4'h2, 2'd2, 4'b0100, 1'b0, 1'b0},
                     {4'h3, 2'd1, 4'b0010, 1'b0, 1'b0}, {4'h4, 2'd0, 4'b0001, 1'b0, 1'b1} };
        do_reset();
        src_data = {16'h5678, 16'h1234};
        src_sel  = 1'b0;
        enable   = 1'b1;
        for (int c = 0; c < 8; c++) begin
            step();
            n_checks++;
            if (obs_a !== exp_tab[c]) begin
                n_errors++;
                $display("FAIL back_to_back cycle %0d: got %h expected %h", c + 1, obs_a, exp_tab[c]);
            end
        end
        enable = 1'b0;
        step();
        n_checks++;
        if (obs_a !== 12'h000) begin
            n_errors++;
            $display("FAIL back_to_back_idle: got %h expected 000", obs_a);
        end
    endtask

    task automatic test_src_switch();
        logic [11:0] exp_tab [8];
        exp_tab = '{ {4'h1, 2'd3, 4'b1000, 1'b1, 1'b0}, {4'h2, 2'd2, 4'b0100, 1'b0, 1'b0},
                     {4'h3, 2'd1, 4'b0010, 1'b0, 1'b0}, {4'h4, 2'd0, 4'b0001, 1'b0, 1'b1},
                     {4'h5, 2'd3, 4'b1000, 1'b1, 1'b0}, {4'h6, 2'd2, 4'b0100, 1'b0, 1'b0},
                     {4'h7, 2'd1, 4'b0010, 1'b0, 1'b0}, {4'h8, 2'd0, 4'b0001, 1'b0, 1'b1} };
        do_reset();
        src_data = {16'h5678, 16'h1234};
        src_sel  = 1'b0;
        enable   = 1'b1;
        for (int c = 0; c < 8; c++) begin
            step();
            n_checks++;
            if (obs_a !== exp_tab[c]) begin
                n_errors++;
                $display("FAIL src_switch cycle %0d: got %h expected %h", c + 1, obs_a, exp_tab[c]);
            end
            if (c == 1) begin
                src_sel  = 1'b1;
                src_data = {16'h5678, 16'hEEEE};
            end
        end
        enable = 1'b0;
        step();
    endtask

    task automatic test_prescale();
        logic [15:0] w;
        logic [11:0] exp_v;
        int ph, d, n_sync, n_fd;
        w = 16'hA0F9;
        n_sync = 0;
        n_fd   = 0;
        do_reset();
        src_data = {16'h5678, w};
        src_sel  = 1'b0;
        enable   = 1'b1;
        for (int c = 0; c < 24; c++) begin
            step();
            ph    = c % 12;
            d     = 3 - ph / 3;
            exp_v = {w[d*4 +: 4], 2'(d), 4'(1 << d), ph == 0, ph == 11};
            n_sync += int'(b_sync);
            n_fd   += int'(b_fd);
            n_checks++;
            if (obs_b !== exp_v) begin
                n_errors++;
                $display("FAIL prescale cycle %0d: got %h expected %h", c, obs_b, exp_v);
            end
        end
        n_checks++;
        if (n_sync != 2 || n_fd != 2) begin
            n_errors++;
            $display("FAIL prescale_strobes: got sync=%0d done=%0d expected 2/2", n_sync, n_fd);
        end
        enable = 1'b0;
        step();
        n_checks++;
        if (obs_b !== 12'h000) begin
            n_errors++;
            $display("FAIL prescale_idle: got %h expected 000", obs_b);
        end
    endtask

    task automatic test_enable_drop();
        logic [11:0] exp_tab [6];
        exp_tab = '{ {4'h1, 2'd3, 4'b1000, 1'b1, 1'b0}, {4'h2, 2'd2, 4'b0100, 1'b0, 1'b0},
                     {4'h3, 2'd1, 4'b0010, 1'b0, 1'b0}, {4'h4, 2'd0, 4'b0001, 1'b0, 1'b1},
                     12'h000, 12'h000 };
        do_reset();
        src_data = {16'h5678, 16'h1234};
        src_sel  = 1'b0;
        enable   = 1'b1;
        for (int c = 0; c < 6; c++) begin
            step();
            n_checks++;
            if (obs_a !== exp_tab[c]) begin
                n_errors++;
                $display("FAIL enable_drop cycle %0d: got %h expected %h", c + 1, obs_a, exp_tab[c]);
            end
            if (c == 2) enable = 1'b0;
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        src_data = {16'h5678, 16'h1234};
        src_sel  = 1'b0;
        enable   = 1'b1;
        step();
        step();
        reset = 1'b1;
        step();
        n_checks++;
        if (obs_a !== 12'h000) begin
            n_errors++;
            $display("FAIL reset_mid: got %h expected 000", obs_a);
        end
        reset = 1'b0;
        step();
        n_checks++;
        if (obs_a !== {4'h1, 2'd3, 4'b1000, 1'b1, 1'b0}) begin
            n_errors++;
            $display("FAIL reset_restart: got %h expected %h", obs_a, {4'h1, 2'd3, 4'b1000, 1'b1, 1'b0});
        end
    endtask

    task automatic test_blank();
        logic [11:0] exp_tab [8];
`ifdef DISP_SCAN_BLANK_EN
        exp_tab = '{ {4'h0, 2'd3, 4'b0000, 1'b1, 1'b0}, {4'h0, 2'd2, 4'b0000, 1'b0, 1'b0},
                     {4'h4, 2'd1, 4'b0010, 1'b0, 1'b0}, {4'h5, 2'd0, 4'b0001, 1'b0, 1'b1},
                     {4'h0, 2'd3, 4'b0000, 1'b1, 1'b0}, {4'h0, 2'd2, 4'b0000, 1'b0, 1'b0},
                     {4'h0, 2'd1, 4'b0000, 1'b0, 1'b0}, {4'h0, 2'd0, 4'b0001, 1'b0, 1'b1} };
`else
        exp_tab = '{ {4'h0, 2'd3, 4'b1000, 1'b1, 1'b0}, {4'h0, 2'd2, 4'b0100, 1'b0, 1'b0},
                     {4'h4, 2'd1, 4'b0010, 1'b0, 1'b0}, {4'h5, 2'd0, 4'b0001, 1'b0, 1'b1},
                     {4'h0, 2'd3, 4'b1000, 1'b1, 1'b0}, {4'h0, 2'd2, 4'b0100, 1'b0, 1'b0},
                     {4'h0, 2'd1, 4'b0010, 1'b0, 1'b0}, {4'h0, 2'd0, 4'b0001, 1'b0, 1'b1} };
`endif
        do_reset();
        src_data = {16'h5678, 16'h0045};
        src_sel  = 1'b0;
        enable   = 1'b1;
        for (int c = 0; c < 8; c++) begin
            step();
            n_checks++;
            if (obs_a !== exp_tab[c]) begin
                n_errors++;
                $display("FAIL blank cycle %0d: got %h expected %h", c + 1, obs_a, exp_tab[c]);
            end
            if (c == 3) src_data = {16'h5678, 16'h0000};
        end
        enable = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_src_switch();
        test_prescale();
        test_enable_drop();
        test_reset_mid();
        test_blank();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/disp_scan.md
Name: disp_scan

Overview:
- Parametrised multi-source, multi-digit display scanner.
- Selects one of NUM_SRC packed BCD/hex words and serialises its nibbles MSB-first onto a 4-bit bus.
- Drives a one-hot digit enable, a frame sync and a frame-done strobe.
- Sits between the calculator datapath registers and the display driver; successor of the fixed two-source, 16-bit display block.

Parameters:
- DIGITS, 4, nibbles per frame (>=2).
- NUM_SRC, 2, number of source words (>=2).
- PRESCALE, 1, clock cycles each digit is held (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- src_data  in  NUM_SRC*DIGITS*4  packed sources; source k occupies bits [k*DIGITS*4 +: DIGITS*4].
- src_sel  in  $clog2(NUM_SRC)  source select.
- enable  in  1  run request.
- display_out  out  4  current nibble.
- digit_idx  out  $clog2(DIGITS)  index of the current digit (DIGITS-1 = most significant).
- digit_en  out  DIGITS  one-hot, bit digit_idx set while a digit is shown.
- sync  out  1  high on the first cycle of the MS digit.
- frame_done  out  1  one-cycle pulse on the last cycle of digit 0.

Behaviour:
- Reset (sync, active-high, dominant over all other inputs):
  - state=IDLE.
  - display_out, digit_idx, digit_en, sync, frame_done all 0.
  - Snapshot register and prescale counter 0.
- State machine, IDLE / SCAN, all outputs registered:
  - IDLE, enable=0: outputs held at reset values.
  - IDLE, enable=1 at edge t: snapshot the selected source word; state becomes SCAN.
  - From cycle t+1 (latency 1): digit_idx=DIGITS-1, display_out = MS nibble of snapshot, digit_en one-hot, sync=1 for that single cycle.
  - SCAN: each digit is held PRESCALE cycles, then digit_idx decrements.
  - frame_done=1 on the final cycle of digit 0.
- End of frame:
  - enable=1 at end of frame: re-snapshot at the same edge; the next cycle is the MS digit of the new frame with sync=1. There is no idle gap between frames.
  - enable=0 at end of frame: next cycle state=IDLE and outputs return to 0.
- enable deasserted mid-frame: the frame completes and is not aborted.
- src_sel and src_data changes mid-frame: ignored until the next snapshot, so there is no tearing.
- src_sel >= NUM_SRC: source 0 is used.
- Reset mid-frame: the next cycle is IDLE with all outputs 0; no frame_done pulse.
- Prescale counter: counts 0..PRESCALE-1 and wraps. With PRESCALE=1, the digit advances every cycle.
- Frame length is exactly DIGITS*PRESCALE cycles. sync and frame_done are each high exactly once per frame.
- When DIGITS=1 is excluded by the parameter rule, sync and frame_done never coincide.

Optional Feature:
- Macro DISP_SCAN_BLANK_EN: leading-zero blanking.
- Defined:
  - Nibbles above the most significant non-zero nibble drive digit_en=0 and display_out=0.
  - digit_idx and sync timing are unchanged.
  - Digit 0 is always shown, so an all-zero word displays a single 0.
  - The blanking mask is computed from the snapshot at snapshot time.
- Undefined: every digit is shown and digit_en is always one-hot during SCAN.

Decomposition:
- Package disp_pkg holds:
  - NIB_W=4.
  - The state enum (IDLE, SCAN).
  - Helper functions for source-slice width (DIGITS*NIB_W) and index width.
- Sub-module disp_prescaler:
  - Parameter PRESCALE.
  - Inputs clk, reset, run.
  - Output tick, high on the last cycle of each hold period.
  - Instantiated once.

Test Plan:
- DIGITS=4, NUM_SRC=2, PRESCALE=1; src0=16'h1234, src_sel=0; enable=1 after reset.
  - Expected: display_out 1,2,3,4 on cycles t+1..t+4.
  - digit_en 1000,0100,0010,0001.
  - sync at t+1, frame_done at t+4.
  - Next frame starts at t+5 with sync=1.
- Same config; switch src_sel=1 (src1=16'h5678) during digit 2.
  - Expected: the current frame still finishes with 3,4; the next frame shows 5,6,7,8.
- PRESCALE=3; src0=16'hA0F9.
  - Expected: each nibble A,0,F,9 held for 3 cycles; frame length 12; one sync and one frame_done per frame.
- enable dropped during digit 1.
  - Expected: the frame completes; the cycle after frame_done shows all outputs 0 and state IDLE.
- reset=1 during digit 2 for one cycle.
  - Expected: the next cycle has all outputs 0 and no frame_done; enable=1 restarts from the MS digit with sync.
- With DISP_SCAN_BLANK_EN; src0=16'h0045.
  - Expected: digits 3 and 2 have digit_en=0000 and display_out=0; then 4 and 5 are shown.
  - src0=16'h0000: only digit 0 is shown, value 0.
